// File: rtl/accum_table_ctrl_if.sv
// Bundle between the matmul control (master) and the accumulator-table
// sequencer (slave). The slave's outputs also fan out to the accumulator
// column bank.
//
// Handshake: clear_start, wr_start and rd_start are single-cycle requests
// that need no acknowledge. A request is taken on a rising edge only while
// busy is low (busy low acts as the ready). A request raised while busy is
// high is dropped, not queued. Every taken request ends with exactly one
// done pulse, unless reset aborts the pass first.
interface accum_table_ctrl_if #(
  parameter int SYS_ARR_COLS = 16,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128
);
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS);
  localparam int ADDR_W = $clog2(NUM_ACCUM_ROWS);
  localparam int ROWS_W = $clog2(MAX_OUT_ROWS + 1);

  logic                           clear_start;
  logic                           wr_start;
  logic [ADDR_W-1:0]              wr_base;
  logic [ROWS_W-1:0]              wr_rows;
  logic                           rd_start;
  logic [ADDR_W-1:0]              rd_base;
  logic [ROWS_W-1:0]              rd_rows;
  logic [SYS_ARR_COLS-1:0]        col_wr_en;
  logic [SYS_ARR_COLS*ADDR_W-1:0] col_wr_addr;
  logic [SYS_ARR_COLS-1:0]        col_rd_en;
  logic [ADDR_W-1:0]              rd_addr;
  logic                           rd_valid;
  logic                           table_clear;
  logic                           busy;
  logic                           done;
  logic [2:0]                     dbg_state;

  modport master (
    output clear_start, wr_start, wr_base, wr_rows, rd_start, rd_base, rd_rows,
    input  col_wr_en, col_wr_addr, col_rd_en, rd_addr, rd_valid,
    input  table_clear, busy, done, dbg_state
  );

  modport slave (
    input  clear_start, wr_start, wr_base, wr_rows, rd_start, rd_base, rd_rows,
    output col_wr_en, col_wr_addr, col_rd_en, rd_addr, rd_valid,
    output table_clear, busy, done, dbg_state
  );
endinterface

// File: rtl/accum_table_ctrl.sv
// Accumulator-table sequencer. It skews per-column write enables and
// addresses to follow the systolic array's output wavefront. It also issues
// parallel drain reads and the table-wide clear strobe. All outputs decode
// from state, the pass counter and latched pass parameters only.
module accum_table_ctrl #(
  parameter int SYS_ARR_COLS = 16,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128
) (
  input  logic               clk,
  input  logic               reset,
  accum_table_ctrl_if.slave  bus
);
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS);
  localparam int ADDR_W = $clog2(NUM_ACCUM_ROWS);
  localparam int CNT_W  = $clog2(MAX_OUT_ROWS + SYS_ARR_COLS);
  localparam int ROWS_W = $clog2(MAX_OUT_ROWS + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WRITE  = 3'd2,
    S_READ   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    t_q, t_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ROWS_W-1:0]   rows_q, rows_d;
  logic                rd_valid_q;

  logic [31:0]             t_ext;
  logic [31:0]             rows_ext;
  logic                    last_wr;
  logic                    last_rd;
  logic                    rd_en;
  logic [SYS_ARR_COLS-1:0] wr_hit;

  assign t_ext    = 32'(t_q);
  assign rows_ext = 32'(rows_q);
  // The write pass covers rows + SYS_ARR_COLS - 1 cycles so the last column drains.
  assign last_wr  = (t_ext == rows_ext + 32'(SYS_ARR_COLS) - 32'd2);
  assign last_rd  = (t_ext == rows_ext - 32'd1);
  assign rd_en    = (state_q == S_READ);

  // State, pass counter and latched pass parameters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      base_q  <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
    end
  end

  // Accumulator read data is registered, so valid trails the read enable by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
    end
  end

  // Next-state logic: starts are taken only in IDLE with priority clear > write > read.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    base_d  = base_q;
    rows_d  = rows_q;
    case (state_q)
      S_IDLE: begin
        t_d = '0;
        if (bus.clear_start) begin
          state_d = S_CLEAR;
        end else if (bus.wr_start) begin
          base_d  = bus.wr_base;
          rows_d  = bus.wr_rows;
          state_d = (bus.wr_rows == '0) ? S_FINISH : S_WRITE;
        end else if (bus.rd_start) begin
          base_d  = bus.rd_base;
          rows_d  = bus.rd_rows;
          state_d = (bus.rd_rows == '0) ? S_FINISH : S_READ;
        end
      end
      S_CLEAR: begin
        state_d = S_FINISH;
      end
      S_WRITE: begin
        t_d = t_q + 1'b1;
        if (last_wr) begin
          t_d     = '0;
          state_d = S_FINISH;
        end
      end
      S_READ: begin
        t_d = t_q + 1'b1;
        if (last_rd) begin
          t_d     = '0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        t_d     = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Column j sees output row r at pass cycle r + j, so it is live for t in [j, j + rows).
  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < SYS_ARR_COLS; j++) begin
      wr_hit[j] = (state_q == S_WRITE) && (t_ext >= 32'(j)) &&
                  (t_ext < 32'(j) + rows_ext);
    end
  end

  // Output decode; idle columns park their address at the pass base.
  always_comb begin
    bus.col_wr_en   = wr_hit;
    bus.col_wr_addr = '0;
    for (int j = 0; j < SYS_ARR_COLS; j++) begin
      bus.col_wr_addr[j*ADDR_W +: ADDR_W] =
        wr_hit[j] ? (base_q + ADDR_W'(t_q) - ADDR_W'(j)) : base_q;
    end
    bus.col_rd_en   = {SYS_ARR_COLS{rd_en}};
    bus.rd_addr     = rd_en ? (base_q + ADDR_W'(t_q)) : base_q;
    bus.rd_valid    = rd_valid_q;
    bus.table_clear = (state_q == S_CLEAR);
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_FINISH);
    bus.dbg_state   = state_q;
  end
endmodule

// File: doc/accum_table_ctrl.md
Name: accum_table_ctrl

Overview:
- Sequencer for the accumulator table: one accumulator column per systolic-array column, SYS_ARR_COLS columns in parallel.
- Drives per-column write enables and addresses with the column skew of the systolic array outputs, so each output tile accumulates into the table.
- Sequences parallel drain reads and issues the table-wide clear.
- Sits between the top-level matmul control and the bank of accumulator columns.

Parameters:
- SYS_ARR_COLS, 16, number of systolic array / accumulator columns
- MAX_OUT_ROWS, 128, output height of the largest matrix
- MAX_OUT_COLS, 128, output width of the largest matrix
- localparam NUM_ACCUM_ROWS = MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS)
- localparam ADDR_W = clog2(NUM_ACCUM_ROWS)
- localparam CNT_W = clog2(MAX_OUT_ROWS+SYS_ARR_COLS)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and zeroes all outputs
- clear_start  in  1  one-cycle request to clear the table
- wr_start  in  1  one-cycle request to begin an accumulate pass
- wr_base  in  ADDR_W  first table row of the pass
- wr_rows  in  clog2(MAX_OUT_ROWS+1)  rows in the pass, 0..MAX_OUT_ROWS
- rd_start  in  1  one-cycle request to begin a drain pass
- rd_base  in  ADDR_W  first table row to drain
- rd_rows  in  clog2(MAX_OUT_ROWS+1)  rows to drain
- col_wr_en  out  SYS_ARR_COLS  per-column write/accumulate enable
- col_wr_addr  out  SYS_ARR_COLS*ADDR_W  per-column write address, column j in bits [j*ADDR_W +: ADDR_W]
- col_rd_en  out  SYS_ARR_COLS  per-column read enable (all bits equal)
- rd_addr  out  ADDR_W  shared read address
- rd_valid  out  1  accumulator read data valid this cycle
- table_clear  out  1  clear strobe to all columns
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse at end of every pass

Behaviour:
- States: IDLE, CLEAR, WRITE, READ, FINISH. Starts are sampled only in IDLE; in any other state they are ignored (no queueing).
- Start priority when several starts are high in the same IDLE cycle: clear > write > read.
- Base and row count are latched at the accepted start edge; later input changes have no effect on the pass.
- Counter t (CNT_W bits) resets to 0 on entry to WRITE/READ and increments each cycle.
- CLEAR: table_clear=1 for exactly one cycle (the cycle after the start edge), then FINISH.
- WRITE: the array emits row r of column j at pass cycle r+j.
  - col_wr_en[j] = 1 iff j <= t < j+rows.
  - col_wr_addr[j] = (base + t - j) mod 2^ADDR_W.
  - Address is held at base when col_wr_en[j] is 0.
  - The state lasts rows+SYS_ARR_COLS-1 cycles, then FINISH.
- READ:
  - col_rd_en all 1 and rd_addr = (base+t) mod 2^ADDR_W for t = 0..rows-1, then FINISH.
  - rd_valid is col_rd_en delayed one cycle, matching the registered accumulator read.
- rows = 0 on a write or read: go straight to FINISH with no enables.
- FINISH:
  - done=1 for one cycle.
  - rd_valid=1 here if the last READ cycle issued a read; done and the last rd_valid coincide.
  - busy=1.
  - Next state IDLE.
- Timing: start edge at cycle k gives the first active cycle k+1. Outputs are decoded only from state, t and latched registers; there is no combinational path from any input to any output.
- Address arithmetic is ADDR_W-bit modulo; wrap past NUM_ACCUM_ROWS-1 to 0 is legal.
- Reset asserted mid-pass aborts the pass immediately (asynchronous):
  - all enables, table_clear, rd_valid, done and busy go to 0; state goes to IDLE, t=0.
  - No done pulse for the aborted pass.
  - The first start is accepted on the first rising edge after reset deasserts.

Test Plan:
Bench parameters: SYS_ARR_COLS=4, MAX_OUT_ROWS=8, MAX_OUT_COLS=8 (ADDR_W=4).
- Reset: assert reset mid-clock in WRITE → all outputs 0 before the next edge. Deassert, then wr_start → pass starts normally.
- Write skew: wr_start, wr_base=2, wr_rows=3.
  - col0 enabled at t=0..2 with addresses 2,3,4; col3 enabled at t=3..5 with addresses 2,3,4.
  - busy high for 7 cycles; done in the 7th.
- Wrap and zero rows:
  - wr_base=14, wr_rows=4 → col1 addresses 14,15,0,1 at t=1..4.
  - Then wr_rows=0 → done in the cycle after the start edge, no col_wr_en.
- Read: rd_base=5, rd_rows=2 → col_rd_en=4'b1111 with rd_addr 5,6 at t=0,1. rd_valid in the next two cycles; done coincides with the second rd_valid.
- Priority and busy:
  - clear_start, wr_start and rd_start in the same cycle → only table_clear, one cycle, then done.
  - wr_start during a WRITE pass is ignored, and the current pass is unchanged.
- Back-to-back: rd_start in the IDLE cycle right after done → accepted. Two full passes complete with no lost or duplicated enables.
